comma_aligner: RTL and testbench
================================

COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 Parameter COMMA_P, default 10'b0101111100, meaning K28.5 RD- pattern with bit0 as the first-received bit.
REQ-002 Parameter COMMA_N, default 10'b1010000011, meaning K28.5 RD+ pattern with bit0 as the first-received bit.
REQ-003 Parameter LOCK_COMMAS, default 3, range 1..15, meaning on-boundary commas required to enter LOCKED.
REQ-004 Parameter LOSS_COUNT, default 4, range 1..15, meaning off-boundary commas tolerated in LOCKED before unlock.
REQ-005 Port clock, input, 1, bit clock; all state updates on its rising edge.
REQ-006 Port Reset, input, 1, synchronous active-high reset.
REQ-007 Port data_in, input, 1, serial received bit, sampled each clock.
REQ-008 Port rxidle, input, 1, electrical idle indication from the receiver I/O.
REQ-009 Port symbol_out, output, 10, last aligned symbol, registered.
REQ-010 Port symbol_strobe, output, 1, one-cycle pulse when symbol_out updates.
REQ-011 Port rxvalid, output, 1, high while state is LOCKED.
REQ-012 Port comma_det, output, 1, registered one-cycle pulse for any comma match at any bit position.
REQ-013 Port align_state, output, 2, state encoding: UNLOCKED=0, CHECK=1, LOCKED=2.

Function
REQ-014 The shift register sr SHALL update every cycle as sr <= {data_in, sr[9:1]}.
REQ-015 The combinational signal hit SHALL be (sr==COMMA_P)|(sr==COMMA_N), and comma_det SHALL equal hit delayed by one clock.
REQ-016 The 4-bit phase counter SHALL count 0..9 and wrap 9->0; boundary is defined as phase==9.
REQ-017 In UNLOCKED, hit SHALL set phase<=0, good<=1 and state<=CHECK; with LOCK_COMMAS==1 it SHALL go directly to LOCKED.
REQ-018 In CHECK, hit&boundary SHALL increment good, and reaching LOCK_COMMAS SHALL enter LOCKED with miss<=0.
REQ-019 In CHECK, hit&!boundary SHALL realign (phase<=0, good<=1) and remain in CHECK.
REQ-020 In LOCKED, hit&boundary SHALL clear miss.
REQ-021 In LOCKED, hit&!boundary SHALL increment miss; reaching LOSS_COUNT SHALL set state<=UNLOCKED and phase<=0.
REQ-022 In LOCKED, non-comma symbols at boundary SHALL have no effect on miss.
REQ-023 In CHECK and LOCKED, boundary SHALL load symbol_out<=sr and assert symbol_strobe the next cycle.
REQ-024 The latency from the last bit of a symbol present on data_in to symbol_strobe high SHALL be 2 clocks.
REQ-025 rxvalid SHALL be a registered (state==LOCKED) signal, falling the cycle after the transition to UNLOCKED.
REQ-026 In UNLOCKED, symbol_strobe SHALL be 0 and symbol_out SHALL hold its last value.
REQ-027 Priority SHALL be Reset > rxidle (when enabled) > comma handling.

Reset
REQ-028 When Reset is high at a rising edge, sr, phase, good, miss, symbol_out, symbol_strobe, rxvalid and comma_det SHALL be set to 0 and align_state to UNLOCKED.
REQ-029 Reset asserted mid-symbol or mid-lock SHALL discard alignment, and the first post-reset hit SHALL be treated as an UNLOCKED hit.

Configuration
REQ-030 Macro COMMA_ALIGNER_RXIDLE_EN: when defined, rxidle high at an edge SHALL force UNLOCKED, clear good and miss, and suppress symbol_strobe that cycle.
REQ-031 When COMMA_ALIGNER_RXIDLE_EN is undefined, the rxidle port SHALL remain present and SHALL be ignored.

Verification
REQ-032 Reset, then three RD- commas spaced 20 bits apart -> align_state 0->1->2, rxvalid=1 two clocks after the third comma's last bit, and symbol_out=10'b0101111100 with strobe every 10 clocks.
REQ-033 In LOCKED, a comma inserted at a 3-bit offset -> comma_det pulse, miss=1, rxvalid stays 1, and the next on-boundary comma clears miss.
REQ-034 In LOCKED, four off-boundary commas with no on-boundary comma between them -> UNLOCKED on the fourth, rxvalid=0 the following cycle, and strobes stop.
REQ-035 In CHECK with good=2, a comma slipped by 1 bit -> good=1, phase realigned, and LOCKED only after two more aligned commas.
REQ-036 In LOCKED, rxidle=1 for one clock with the macro defined -> UNLOCKED and no strobe; without the macro -> LOCKED is kept and strobes continue.
REQ-037 Reset pulsed while LOCKED, 5 bits into a symbol -> all outputs 0 next cycle, and relock requires LOCK_COMMAS fresh commas.

Source files
------------

// File: rtl/comma_aligner.sv
// Serial 8b/10b comma aligner: finds K28.5 in the bit stream, locks symbol
// boundaries and emits aligned 10-bit symbols. Define COMMA_ALIGNER_RXIDLE_EN to let rxidle drop lock.
module comma_aligner #(
  parameter logic [9:0] COMMA_P     = 10'b0101111100,
  parameter logic [9:0] COMMA_N     = 10'b1010000011,
  parameter int         LOCK_COMMAS = 3,
  parameter int         LOSS_COUNT  = 4
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       data_in,
  input  logic       rxidle,
  output logic [9:0] symbol_out,
  output logic       symbol_strobe,
  output logic       rxvalid,
  output logic       comma_det,
  output logic [1:0] align_state
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } align_state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  align_state_t state;
  logic [9:0]   sr;
  logic [3:0]   phase;
  logic [3:0]   good;
  logic [3:0]   miss;
  logic         hit;
  logic         boundary;
  logic         idle_force;

  assign hit         = (sr == COMMA_P) | (sr == COMMA_N);
  assign boundary    = (phase == 4'd9);
  assign align_state = state;

`ifdef COMMA_ALIGNER_RXIDLE_EN
  assign idle_force = rxidle;
`else
  logic unused_rxidle;
  assign unused_rxidle = rxidle;
  assign idle_force    = 1'b0;
`endif

  // The phase counter free-runs; a comma seen while hunting or off-frame
  // restarts it so that phase==9 marks the cycle a whole symbol sits in sr.
  always_ff @(posedge clock) begin
    if (Reset) begin
      sr            <= '0;
      phase         <= '0;
      good          <= '0;
      miss          <= '0;
      symbol_out    <= '0;
      symbol_strobe <= 1'b0;
      rxvalid       <= 1'b0;
      comma_det     <= 1'b0;
      state         <= UNLOCKED;
    end else begin
      sr            <= {data_in, sr[9:1]};
      comma_det     <= hit;
      rxvalid       <= (state == LOCKED);
      symbol_strobe <= 1'b0;
      phase         <= boundary ? 4'd0 : phase + 4'd1;

      if (idle_force) begin
        state <= UNLOCKED;
        good  <= '0;
        miss  <= '0;
      end else begin
        case (state)
          UNLOCKED: begin
            if (hit) begin
              phase <= 4'd0;
              good  <= 4'd1;
              if (LOCK_N == 4'd1) begin
                state <= LOCKED;
                miss  <= '0;
              end else begin
                state <= CHECK;
              end
            end
          end

          CHECK: begin
            if (boundary) begin
              symbol_out    <= sr;
              symbol_strobe <= 1'b1;
              if (hit) begin
                good <= good + 4'd1;
                if (good + 4'd1 >= LOCK_N) begin
                  state <= LOCKED;
                  miss  <= '0;
                end
              end
            end else if (hit) begin
              phase <= 4'd0;
              good  <= 4'd1;
            end
          end

          LOCKED: begin
            if (boundary) begin
              symbol_out    <= sr;
              symbol_strobe <= 1'b1;
              if (hit)
                miss <= '0;
            end else if (hit) begin
              miss <= miss + 4'd1;
              if (miss + 4'd1 >= LOSS_N) begin
                state <= UNLOCKED;
                phase <= 4'd0;
              end
            end
          end

          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: acquisition, off-frame commas, loss of
// lock, slip during CHECK, rxidle and mid-lock reset.
module tb_comma_aligner;

  localparam logic [9:0] C = 10'b0101111100;
  localparam logic [9:0] Z = 10'b0000000000;

  logic       clock = 1'b0;
  logic       Reset;
  logic       data_in;
  logic       rxidle;
  logic [9:0] symbol_out;
  logic       symbol_strobe;
  logic       rxvalid;
  logic       comma_det;
  logic [1:0] align_state;

  always #5 clock = ~clock;

  comma_aligner dut (
    .clock         (clock),
    .Reset         (Reset),
    .data_in       (data_in),
    .rxidle        (rxidle),
    .symbol_out    (symbol_out),
    .symbol_strobe (symbol_strobe),
    .rxvalid       (rxvalid),
    .comma_det     (comma_det),
    .align_state   (align_state)
  );

  typedef struct {
    logic [9:0] st;
    logic [9:0] rxv;
    logic [9:0] stb;
    logic [9:0] det;
    logic [9:0] sym;
  } obs_t;

  obs_t obs [40];
  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Drives bits first-received-first; obs[i] holds outputs 1 time unit after bit i's edge.
  task automatic applyStimulus(input logic [39:0] bits, input int n, input logic idle_first);
    for (int i = 0; i < n; i++) begin
      data_in = bits[i];
      rxidle  = idle_first && (i == 0);
      @(posedge clock);
      #1;
      obs[i].st  = 10'(align_state);
      obs[i].rxv = 10'(rxvalid);
      obs[i].stb = 10'(symbol_strobe);
      obs[i].det = 10'(comma_det);
      obs[i].sym = symbol_out;
    end
    rxidle = 1'b0;
  endtask

  task automatic send_sym(input logic [9:0] s);
    applyStimulus({30'b0, s}, 10, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] strobe_count(input int n);
    logic [9:0] s = '0;
    for (int i = 0; i < n; i++) s = s + obs[i].stb;
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_state"}, 10'(align_state), 10'd0);
    checkOutput({tag, "_rxvalid"}, 10'(rxvalid), 10'd0);
    checkOutput({tag, "_strobe"}, 10'(symbol_strobe), 10'd0);
    checkOutput({tag, "_det"}, 10'(comma_det), 10'd0);
    checkOutput({tag, "_sym"}, symbol_out, 10'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [39:0] off_comma;
    off_comma = 40'(C) << 3;

    Reset   = 1'b1;
    data_in = 1'b0;
    rxidle  = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    Reset = 1'b0;
    check_reset_outputs("reset");

    // Acquisition: three commas 20 bits apart
    send_sym(C);
    send_sym(Z);
    checkOutput("acq_enter_check", obs[0].st, 10'd1);
    checkOutput("acq_det_pulse", obs[0].det, 10'd1);
    checkOutput("acq_det_clear", obs[1].det, 10'd0);
    checkOutput("acq_no_strobe_unlocked", obs[0].stb, 10'd0);
    send_sym(C);
    checkOutput("acq_filler_strobe", obs[0].stb, 10'd1);
    checkOutput("acq_filler_sym", obs[0].sym, Z);
    send_sym(Z);
    checkOutput("acq_good2_state", obs[0].st, 10'd1);
    checkOutput("acq_comma2_sym", obs[0].sym, C);
    send_sym(C);
    send_sym(Z);
    checkOutput("acq_locked", obs[0].st, 10'd2);
    checkOutput("acq_rxvalid_lag", obs[0].rxv, 10'd0);
    checkOutput("acq_rxvalid", obs[1].rxv, 10'd1);
    checkOutput("acq_comma3_sym", obs[0].sym, C);
    checkOutput("acq_comma3_strobe", obs[0].stb, 10'd1);
    send_sym(Z);
    checkOutput("acq_strobe_period", strobe_count(10), 10'd1);

    // Single comma 3 bits off the frame while locked
    applyStimulus(off_comma, 20, 1'b0);
    checkOutput("off_det_quiet", obs[12].det, 10'd0);
    checkOutput("off_det_pulse", obs[13].det, 10'd1);
    checkOutput("off_still_locked", obs[13].st, 10'd2);
    checkOutput("off_rxvalid_kept", obs[14].rxv, 10'd1);
    checkOutput("off_boundary_strobe", obs[10].stb, 10'd1);
    send_sym(C);
    checkOutput("off_partial_sym", obs[0].sym, C >> 7);
    send_sym(Z);
    checkOutput("off_realigned_comma", obs[0].sym, C);

    // Miss count was cleared, so three more off-frame commas keep lock, the fourth drops it
    for (int k = 0; k < 3; k++) begin
      applyStimulus(off_comma, 20, 1'b0);
      checkOutput($sformatf("loss_keep_%0d", k), obs[13].st, 10'd2);
    end
    applyStimulus(off_comma, 20, 1'b0);
    checkOutput("loss_unlock", obs[13].st, 10'd0);
    checkOutput("loss_rxvalid_lag", obs[13].rxv, 10'd1);
    checkOutput("loss_rxvalid_drop", obs[14].rxv, 10'd0);
    send_sym(Z);
    checkOutput("loss_strobes_stop", strobe_count(10), 10'd0);

    // Slip by one bit while CHECK holds two good commas
    send_sym(C);
    send_sym(Z);
    send_sym(C);
    send_sym(Z);
    checkOutput("slip_pre_state", obs[0].st, 10'd1);
    applyStimulus(40'(C) << 1, 11, 1'b0);
    checkOutput("slip_old_boundary_sym", obs[10].sym, C << 1);
    send_sym(Z);
    checkOutput("slip_stay_check", obs[0].st, 10'd1);
    checkOutput("slip_det", obs[0].det, 10'd1);
    send_sym(C);
    send_sym(Z);
    checkOutput("slip_not_locked_yet", obs[0].st, 10'd1);
    checkOutput("slip_new_frame_sym", obs[0].sym, C);
    send_sym(C);
    send_sym(Z);
    checkOutput("slip_locked", obs[0].st, 10'd2);

    // One clock of rxidle on a boundary cycle
    applyStimulus({30'b0, Z}, 10, 1'b1);
`ifdef COMMA_ALIGNER_RXIDLE_EN
    checkOutput("idle_unlock", obs[0].st, 10'd0);
    checkOutput("idle_no_strobe", obs[0].stb, 10'd0);
    send_sym(Z);
    checkOutput("idle_strobes_stop", obs[0].stb, 10'd0);
    send_sym(C); send_sym(Z);
    send_sym(C); send_sym(Z);
    send_sym(C); send_sym(Z);
    checkOutput("idle_relock", obs[0].st, 10'd2);
`else
    checkOutput("idle_ignored_state", obs[0].st, 10'd2);
    checkOutput("idle_ignored_strobe", obs[0].stb, 10'd1);
    send_sym(Z);
    checkOutput("idle_strobes_continue", obs[0].stb, 10'd1);
`endif

    // Reset five bits into a symbol while locked
    applyStimulus({30'b0, C}, 5, 1'b0);
    Reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clock); #1;
    Reset = 1'b0;
    check_reset_outputs("midreset");
    send_sym(C);
    send_sym(Z);
    checkOutput("relock_first", obs[0].st, 10'd1);
    send_sym(C);
    send_sym(Z);
    checkOutput("relock_second", obs[0].st, 10'd1);
    send_sym(C);
    send_sym(Z);
    checkOutput("relock_third", obs[0].st, 10'd2);
    checkOutput("relock_rxvalid", obs[1].rxv, 10'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
